hop_fifo: RTL and testbench
===========================

// Module: hop_fifo
// PURPOSE
//   Elastic buffer directly upstream of the PARENT hop: accepts a WIDTH-bit
//   stream with valid/ready handshake and presents it, in order, to the net
//   that drives PARENT.I. Absorbs bursts when the consumer stalls, and gives the
//   net_attr tests a sequential producer on the hop net.
// PARAMETERS
//   WIDTH   1   data bits per entry (>=1)
//   DEPTH   4   entries of storage; power of two, >=2
// PORTS
//   clk      in   1                  single clock, all state on rising edge
//   rst      in   1                  synchronous, active-high reset
//   I        in   WIDTH              write data
//   I_VALID  in   1                  write request
//   I_READY  out  1                  space available (push accepted if I_VALID&I_READY)
//   O        out  WIDTH              head-of-queue data (feeds PARENT.I)
//   O_VALID  out  1                  queue non-empty
//   O_READY  in   1                  consumer takes head (pop if O_VALID&O_READY)
//   LEVEL    out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (rst=1 at an edge): wr_ptr=rd_ptr=0, LEVEL=0, O_VALID=0, I_READY=1,
//     O=0. Storage array not reset; contents are don't-care after reset.
//   - Reset mid-operation discards all queued entries; a push/pop presented in
//     the reset cycle is ignored.
//   - push = I_VALID & I_READY; pop = O_VALID & O_READY. Both evaluated on the
//     same edge; both may occur in one cycle (LEVEL unchanged).
//   - I_READY = (LEVEL != DEPTH); O_VALID = (LEVEL != 0). Both are decoded from
//     registered state only; no combinational path from I_VALID/O_READY to
//     I_READY/O_VALID.
//   - Show-ahead read: O = mem[rd_ptr] while O_VALID=1; O forced to 0 while
//     O_VALID=0 (no X on the hop net).
//   - Latency: entry pushed at edge N appears on O after edge N when the queue
//     was empty (O_VALID=1 in cycle N+1). No bypass in the same cycle.
//   - Full: I_READY=0; a pop in that cycle frees a slot and I_READY=1 the
//     following cycle (no ready pass-through).
//   - Empty: O_VALID=0; O_READY ignored, no underflow; LEVEL never wraps.
//   - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; LEVEL is tracked
//     separately so full vs. empty is unambiguous.
//   - LEVEL next = LEVEL + push - pop, width $clog2(DEPTH)+1, saturating
//     impossible by construction (assert 0<=LEVEL<=DEPTH in simulation).
//   - Data order strictly FIFO; no entry dropped or duplicated.
// STRUCTURE
//   - Shared package hop_pkg: HOP_PTR_W(depth) and HOP_LVL_W(depth) width
//     functions, default WIDTH/DEPTH constants reused by PARENT-level tests.
//   - Sub-module hop_fifo_mem: DEPTH x WIDTH register array, one synchronous
//     write port (we, waddr, wdata), one asynchronous read port (raddr, rdata).
//   - hop_fifo top holds pointers, LEVEL counter, handshake decode, O gating.
// TESTING
//   1. rst=1 two cycles, release -> LEVEL=0, O_VALID=0, I_READY=1, O=0.
//   2. Push 0x1,0x0,0x1 (WIDTH=1) with O_READY=0 -> LEVEL=3; then O_READY=1 ->
//      O sequence 1,0,1 over 3 cycles, LEVEL 3->0, O_VALID drops after last pop.
//   3. DEPTH=4, push 4 entries with O_READY=0 -> I_READY=0 at LEVEL=4; 5th
//      I_VALID held -> not accepted; one pop -> I_READY=1 next cycle, 5th taken.
//   4. WIDTH=8: continuous I_VALID=O_READY=1 streaming 0x00..0x3F -> output
//      identical order, LEVEL steady at 1 after fill, pointers wrap 16 times.
//   5. Queue holds 3 entries, assert rst for one cycle with I_VALID=O_READY=1
//      -> LEVEL=0, O_VALID=0 next cycle, no entry emerges afterwards.
//   6. Empty queue, O_READY=1 for 10 cycles, no pushes -> LEVEL stays 0, O=0.

Source files
------------

// File: rtl/hop_pkg.sv
// Shared constants and width helpers for the hop elastic buffer and the
// PARENT-level tests that instantiate it.
package hop_pkg;

  localparam int HOP_WIDTH = 1;
  localparam int HOP_DEPTH = 4;

  // Pointer width; kept at least one bit so tiny depths still elaborate.
  function automatic int HOP_PTR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter needs one extra bit to represent a full queue.
  function automatic int HOP_LVL_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hop_fifo_if.sv
// Handshake bundle between a stream producer/consumer and hop_fifo.
// The master side drives write data and read-ready; the FIFO is the slave.
interface hop_fifo_if
  import hop_pkg::*;
#(
  parameter int WIDTH = HOP_WIDTH,
  parameter int DEPTH = HOP_DEPTH
);

  logic [WIDTH-1:0]            I;
  logic                        I_VALID;
  logic                        I_READY;
  logic [WIDTH-1:0]            O;
  logic                        O_VALID;
  logic                        O_READY;
  logic [HOP_LVL_W(DEPTH)-1:0] LEVEL;

  modport master (
    output I, I_VALID, O_READY,
    input  I_READY, O, O_VALID, LEVEL
  );

  modport slave (
    input  I, I_VALID, O_READY,
    output I_READY, O, O_VALID, LEVEL
  );

endinterface

// File: rtl/hop_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read
// port so the head entry is visible in the same cycle it is addressed.
module hop_fifo_mem
  import hop_pkg::*;
#(
  parameter int WIDTH = HOP_WIDTH,
  parameter int DEPTH = HOP_DEPTH,
  parameter int PTR_W = HOP_PTR_W(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are intentionally not reset; the top gates O while empty.
  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/hop_fifo.sv
// Elastic FIFO upstream of the PARENT hop: show-ahead output, registered
// ready/valid flags, explicit occupancy counter for unambiguous full/empty.
module hop_fifo
  import hop_pkg::*;
#(
  parameter int WIDTH = HOP_WIDTH,
  parameter int DEPTH = HOP_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  hop_fifo_if.slave bus
);

  localparam int PW = HOP_PTR_W(DEPTH);
  localparam int LW = HOP_LVL_W(DEPTH);

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic             push, pop;
  logic [WIDTH-1:0] rdata;

  // Flags come only from level_reg, so no input-to-flag combinational path.
  assign bus.I_READY = (level_reg != LW'(DEPTH));
  assign bus.O_VALID = (level_reg != '0);
  assign bus.LEVEL   = level_reg;

  assign push = bus.I_VALID & bus.I_READY;
  assign pop  = bus.O_VALID & bus.O_READY;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  hop_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wr_ptr_reg),
    .wdata (bus.I),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

  // Keep the hop net at a known value whenever nothing is queued.
  assign bus.O = bus.O_VALID ? rdata : '0;

  always @(posedge clk) begin
    if (!rst) begin
      assert (level_reg <= LW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_hop_fifo.sv
// Self-checking bench for hop_fifo: directed scenarios plus random traffic,
// scored against a queue model of the expected FIFO contents.
module tb_hop_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  hop_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  hop_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [WIDTH-1:0] exp_q [$];
  int  checks   = 0;
  int  failures = 0;
  bit  done     = 1'b0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  // One clock of stimulus; an accepted push records its data as expected output.
  task automatic cyc(input logic rs, input logic v, input logic r,
                     input logic [WIDTH-1:0] d, output logic acc);
    rst         = rs;
    bus.I_VALID = v;
    bus.O_READY = r;
    bus.I       = d;
    @(negedge clk);
    acc = !rs && v && bus.I_READY;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the model on every handshake and compares the head.
  initial begin
    logic [WIDTH-1:0] want;
    forever begin
      @(negedge clk);
      if (done) break;
      if (rst) begin
        exp_q.delete();
      end else if (bus.O_VALID) begin
        if (bus.O_READY) begin
          if (exp_q.size() == 0) begin
            chk("pop_with_empty_model", 1, 0);
          end else begin
            want = exp_q.pop_front();
            chk("pop_data", int'(bus.O), int'(want));
          end
        end
      end else begin
        chk("o_zero_when_empty", int'(bus.O), 0);
      end
    end
  end

  // Status monitor: after each edge, flags and LEVEL must match model occupancy.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      chk("level", int'(bus.LEVEL), exp_q.size());
      chk("o_valid", int'(bus.O_VALID), int'(exp_q.size() != 0));
      chk("i_ready", int'(bus.I_READY), int'(exp_q.size() != DEPTH));
    end
  end

  initial begin
    logic acc;
    bus.I = '0; bus.I_VALID = 1'b0; bus.O_READY = 1'b0; rst = 1'b1;

    // Reset for two cycles.
    cyc(1, 0, 0, 8'h00, acc);
    cyc(1, 0, 0, 8'h00, acc);
    chk("rst_level", int'(bus.LEVEL), 0);
    chk("rst_o", int'(bus.O), 0);

    // Push 1,0,1 while stalled, then drain.
    cyc(0, 1, 0, 8'h01, acc);
    cyc(0, 1, 0, 8'h00, acc);
    cyc(0, 1, 0, 8'h01, acc);
    chk("three_level", int'(bus.LEVEL), 3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h00, acc);

    // Fill to DEPTH, hold a fifth push through a pop.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 0, 8'(8'h10 + i), acc);
      chk("fill_acc", int'(acc), 1);
    end
    cyc(0, 1, 0, 8'hA5, acc);
    chk("full_reject", int'(acc), 0);
    cyc(0, 1, 1, 8'hA5, acc);
    chk("full_pop_no_pass", int'(acc), 0);
    cyc(0, 1, 0, 8'hA5, acc);
    chk("fifth_taken", int'(acc), 1);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 8'h00, acc);

    // Continuous streaming 0x00..0x3F.
    for (int i = 0; i < 64; i++) begin
      cyc(0, 1, 1, 8'(i), acc);
      chk("stream_acc", int'(acc), 1);
    end
    cyc(0, 0, 1, 8'h00, acc);

    // Reset with three entries queued and a push/pop presented.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'(8'h20 + i), acc);
    cyc(1, 1, 1, 8'hEE, acc);
    chk("mid_rst_level", int'(bus.LEVEL), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h00, acc);

    // Idle pops on an empty queue.
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'h00, acc);
    chk("idle_o", int'(bus.O), 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 63) == 0),
          logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 2) != 0),
          8'($urandom), acc);
    end

    // Drain with a bounded cycle budget.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(0, 0, 1, 8'h00, acc);
    chk("drain_empty", exp_q.size(), 0);
    cyc(0, 0, 0, 8'h00, acc);

    done = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
